// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor:
// FSM state encoding and the default operand width.
package sub_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = a - b - bin.
// Ports: a, b, bin (borrow in) -> d (difference), bout (borrow out).
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic axb;

  assign axb  = a ^ b;
  assign d    = axb ^ bin;
  assign bout = (~a & b) | (~axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high), start, a, b -> busy, done, diff, borrow_out.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             bor;
  logic [CW-1:0]    cnt;

  logic             d_bit;
  logic             b_next;
  logic [WIDTH-1:0] res_next;

  full_sub_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bor),
    .d    (d_bit),
    .bout (b_next)
  );

  // New difference bit enters at the MSB so that after WIDTH
  // steps the LSB-first stream sits in natural bit order.
  assign res_next = {d_bit, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      bor        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            bor    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          bor    <= b_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= res_next;
            borrow_out <= b_next;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor (WIDTH=8)
// and the full_sub_cell truth table.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  logic ca, cb, cbin, cd, cbo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  full_sub_cell u_cell (
    .a    (ca),
    .b    (cb),
    .bin  (cbin),
    .d    (cd),
    .bout (cbo)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and follow it to the done pulse, then
  // step one more edge so the DUT is back in IDLE on return.
  task automatic run_op(input logic [W-1:0] ai,
                        input logic [W-1:0] bi,
                        output int busy_n,
                        output int seen_done,
                        output int overlap);
    a = ai;
    b = bi;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_n = 0;
    seen_done = 0;
    overlap = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy && done) overlap = 1;
      if (done) begin
        seen_done = 1;
        break;
      end
      if (busy) busy_n++;
      tick();
    end
    tick();
  endtask

  task automatic op_chk(input string tag,
                        input logic [W-1:0] ai,
                        input logic [W-1:0] bi);
    int bn, sd, ov;
    logic [W:0] ref_v;
    ref_v = {1'b0, ai} - {1'b0, bi};
    run_op(ai, bi, bn, sd, ov);
    chk({tag, ".done"}, sd, 1);
    chk({tag, ".diff"}, diff, ref_v[W-1:0]);
    chk({tag, ".borrow"}, borrow_out, ref_v[W]);
  endtask

  initial begin
    logic [1:0] tt [8];
    int bn, sd, ov, ndone;
    logic [W-1:0] ra, rb;
    logic [W:0] rv;

    tt[0] = 2'b00; tt[1] = 2'b11; tt[2] = 2'b11; tt[3] = 2'b01;
    tt[4] = 2'b10; tt[5] = 2'b00; tt[6] = 2'b00; tt[7] = 2'b11;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {ca, cb, cbin} = v;
      #1;
      chk($sformatf("cell%0d", i), {30'd0, cd, cbo}, {30'd0, tt[i]});
    end

    rst = 1'b1;
    start = 1'b1;
    a = 8'h55;
    b = 8'h11;
    tick();
    tick();
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.diff", diff, 0);
    chk("rst.borrow", borrow_out, 0);
    start = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle.busy", busy, 0);

    run_op(8'h05, 8'h03, bn, sd, ov);
    chk("op1.busy_cycles", bn, 8);
    chk("op1.done", sd, 1);
    chk("op1.overlap", ov, 0);
    chk("op1.diff", diff, 8'h02);
    chk("op1.borrow", borrow_out, 0);
    repeat (3) tick();
    chk("hold.diff", diff, 8'h02);
    chk("hold.done", done, 0);

    op_chk("op2", 8'h03, 8'h05);
    chk("op2.diff_fe", diff, 8'hFE);
    op_chk("op3", 8'h00, 8'hFF);
    chk("op3.borrow1", borrow_out, 1);
    op_chk("op4", 8'hFF, 8'h00);
    op_chk("op5", 8'h00, 8'h00);
    op_chk("op6", 8'hA5, 8'hA6);

    // Start re-pulsed mid-operation with new operands must be ignored.
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    tick();
    a = 8'h00;
    b = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          chk("repulse.diff", diff, 8'h0F);
          chk("repulse.borrow", borrow_out, 0);
        end
      end
      tick();
    end
    chk("repulse.ndone", ndone, 1);

    // Reset in the middle of SHIFT.
    a = 8'h80;
    b = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("mid.busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid.busy", busy, 0);
    chk("mid.done", done, 0);
    chk("mid.diff", diff, 0);
    chk("mid.borrow", borrow_out, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("mid.no_done", ndone, 0);
    op_chk("after_rst", 8'h80, 8'h01);
    chk("after_rst.diff7f", diff, 8'h7F);

    // Random back-to-back operations.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rv = {1'b0, ra} - {1'b0, rb};
      run_op(ra, rb, bn, sd, ov);
      if (!(sd == 1 && bn == W && ov == 0 &&
            diff === rv[W-1:0] && borrow_out === rv[W])) begin
        chk($sformatf("rnd%0d.a%0h.b%0h.diff", n, ra, rb),
            {23'd0, borrow_out, diff}, {23'd0, rv});
        chk($sformatf("rnd%0d.timing", n),
            {sd[7:0], bn[7:0], ov[7:0]}, {8'd1, 8'(W), 8'd0});
      end else begin
        chk("rnd.ok", {23'd0, borrow_out, diff}, {23'd0, rv});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous reset, active-high.
REQ-005 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-006 Port: a  input  WIDTH  minuend, unsigned; captured on accepted start.
REQ-007 Port: b  input  WIDTH  subtrahend, unsigned; captured on accepted start.
REQ-008 Port: busy  output  1  high while the SHIFT state is active.
REQ-009 Port: done  output  1  one-cycle pulse; result is valid.
REQ-010 Port: diff  output  WIDTH  a minus b, modulo 2^WIDTH.
REQ-011 Port: borrow_out  output  1  final borrow; high exactly when a < b (unsigned).

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; the state register resets to IDLE.
REQ-013 IDLE with start=1 at edge k: load a and b into shift registers, clear the borrow flip-flop and bit counter, enter SHIFT.
REQ-014 IDLE with start=0: remain in IDLE; diff and borrow_out hold their previous values.
REQ-015 Each SHIFT edge: one full-subtractor step on operand LSBs plus the borrow FF.
REQ-016 Each SHIFT edge: difference bit = a0 XOR b0 XOR bin.
REQ-017 Each SHIFT edge: next borrow = (~a0 & b0) | (~(a0 XOR b0) & bin).
REQ-018 Each SHIFT edge: the difference bit enters the MSB of the result register, which shifts right; both operand registers shift right; the counter increments.
REQ-019 SHIFT ends after exactly WIDTH steps: the edge that completes step WIDTH (edge k+WIDTH) enters DONE.
REQ-020 DONE lasts one cycle: done=1, diff holds the full result, borrow_out holds the final borrow, next state is IDLE.
REQ-021 Latency: start accepted at edge k gives done high during the cycle after edge k+WIDTH; the next start is accepted no earlier than edge k+WIDTH+2.
REQ-022 busy=1 for exactly WIDTH cycles per operation; busy and done are never high together.
REQ-023 start while in SHIFT or DONE is ignored; it is not queued, and a and b changes do not affect the operation in flight.
REQ-024 diff and borrow_out update only on entry to DONE (no partial results visible); they are stable from that point until the next entry to DONE.
REQ-025 Arithmetic: diff = (a - b) mod 2^WIDTH; borrow_out equals bit WIDTH of the (WIDTH+1)-bit difference.

Reset
REQ-026 rst=1 at any edge, including mid-SHIFT: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, operand and borrow registers=0.
REQ-027 rst overrides start at the same edge; no operation begins.
REQ-028 After rst deasserts, the first start is accepted normally.

Structure
REQ-029 Shared package sub_pkg holds the state enumeration (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-030 The single-bit step is a combinational sub-module full_sub_cell (inputs a, b, bin; outputs d, bout), instantiated once.
REQ-031 Counter width is clog2(WIDTH+1).

Verification
REQ-032 WIDTH=8: rst, then start with a=0x05, b=0x03 -> busy high 8 cycles, done pulse at cycle 9, diff=0x02, borrow_out=0.
REQ-033 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; a=0x00, b=0xFF -> diff=0x01, borrow_out=1; a=0xFF, b=0x00 -> diff=0xFF, borrow_out=0; a=b=0x00 -> diff=0x00, borrow_out=0.
REQ-034 full_sub_cell: all 8 {a,b,bin} combinations -> d/bout match the truth table (000->00, 001->11, 010->11, 011->01, 100->10, 101->00, 110->00, 111->11).
REQ-035 Start 0x10-0x01, re-pulse start with a=0x00, b=0x00 at cycle 3 -> re-pulse ignored; result diff=0x0F, borrow_out=0; exactly one done pulse.
REQ-036 rst asserted at cycle 4 of SHIFT -> next cycle busy=0, done=0, diff=0x00, borrow_out=0, no done pulse; a following start with 0x80-0x01 -> diff=0x7F.
REQ-037 Random unsigned operand pairs over 1000 operations, back-to-back starts -> every result matches the (a-b) reference model.
